// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Decoder honours MIPS_CTRL_BRANCH_EN (BEQ/BNE legal when defined).
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_FUNCT  = 4'd2;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;

    // One-hot instruction class; all-zero means unsupported.
    typedef struct packed {
        logic addu;
        logic jr;
        logic addiu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
    } instr_cls_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decoder.sv
// Combinational op/funct decoder: one-hot instruction class plus legal flag.
// BEQ/BNE are only recognised when MIPS_CTRL_BRANCH_EN is defined.
module mips_ctrl_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [6:0] cls_o,
    output logic       legal_o
);

    instr_cls_t cls;

    always_comb begin
        cls = '0;
        case (op_i)
            OP_RTYPE: begin
                cls.addu = (funct_i == FUNCT_ADDU);
                cls.jr   = (funct_i == FUNCT_JR);
            end
            OP_ADDIU: cls.addiu = 1'b1;
            OP_LW:    cls.lw    = 1'b1;
            OP_SW:    cls.sw    = 1'b1;
`ifdef MIPS_CTRL_BRANCH_EN
            OP_BEQ:   cls.beq   = 1'b1;
            OP_BNE:   cls.bne   = 1'b1;
`else
`endif
            default: ;
        endcase
    end

    assign cls_o   = cls;
    assign legal_o = |cls;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (ADDU, JR, ADDIU, LW, SW; BEQ/BNE with MIPS_CTRL_BRANCH_EN).
// Outputs decode combinationally from state/op/funct/waitrequest and are zero while in reset.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_i,
    input  logic [5:0]         funct_i,
    input  logic               waitrequest_i,
    input  logic               alu_zero_i,
    input  logic               jr_tgt_zero_i,
    output logic               active_o,
    output logic               illegal_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               i_or_d_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_to_reg_o,
    output logic               ir_write_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         pc_source_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [STATE_W-1:0] state_o
);

    logic [6:0] cls_raw;
    instr_cls_t cls;
    logic       legal;

    mips_ctrl_decoder u_decoder (
        .op_i    (op_i),
        .funct_i (funct_i),
        .cls_o   (cls_raw),
        .legal_o (legal)
    );

    assign cls = instr_cls_t'(cls_raw);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        ctrl      = '0;
        case (state_q)
            StFetch: begin
                ctrl.mem_read = 1'b1;
                if (!waitrequest_i) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    state_d        = StDecode;
                end
            end
            StDecode: begin
                // Branch target precomputed here regardless of instruction.
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                state_d = StFetch;
                if (cls.addu) begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALU_FUNCT;
                    state_d        = StWb;
                end else if (cls.addiu || cls.lw || cls.sw) begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                    state_d        = cls.addiu ? StWb : StMem;
                end else if (cls.jr) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_RS;
                    state_d        = jr_tgt_zero_i ? StHalt : StFetch;
                end else if (cls.beq || cls.bne) begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_RT;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    ctrl.pc_write_cond = (cls.beq && alu_zero_i) || (cls.bne && !alu_zero_i);
                end
            end
            StMem: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = cls.lw;
                ctrl.mem_write = cls.sw;
                if (!waitrequest_i) begin
                    state_d = cls.lw ? StWb : StFetch;
                end
            end
            StWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = cls.addu;
                ctrl.mem_to_reg = cls.lw;
                state_d         = StFetch;
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
        // Async reset kills any in-flight memory access in the same cycle.
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign active_o        = rst_n && (state_q != StHalt);
    assign illegal_o       = rst_n && illegal_q;
    assign state_o         = rst_n ? STATE_W'(state_q) : '0;
    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign i_or_d_o        = ctrl.i_or_d;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign ir_write_o      = ctrl.ir_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign pc_source_o     = ctrl.pc_source;
    assign alu_op_o        = ALUOP_W'(ctrl.alu_op);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl; branch case follows MIPS_CTRL_BRANCH_EN.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       waitrequest = 1'b0;
    logic       alu_zero = 1'b0;
    logic       jr_tgt_zero = 1'b0;

    logic       active, illegal, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic [2:0] state;

    mips_multicycle_ctrl #(
        .ALUOP_W (4),
        .STATE_W (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_i            (op),
        .funct_i         (funct),
        .waitrequest_i   (waitrequest),
        .alu_zero_i      (alu_zero),
        .jr_tgt_zero_i   (jr_tgt_zero),
        .active_o        (active),
        .illegal_o       (illegal),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .i_or_d_o        (i_or_d),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_to_reg_o    (mem_to_reg),
        .ir_write_o      (ir_write),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .pc_source_o     (pc_source),
        .alu_op_o        (alu_op),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    logic [17:0] ctl_act;
    assign ctl_act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
                      reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op};

    localparam logic [17:0] PCW    = 18'd1 << 17;
    localparam logic [17:0] PCWC   = 18'd1 << 16;
    localparam logic [17:0] IORD   = 18'd1 << 15;
    localparam logic [17:0] MRD    = 18'd1 << 14;
    localparam logic [17:0] MWR    = 18'd1 << 13;
    localparam logic [17:0] MTR    = 18'd1 << 12;
    localparam logic [17:0] IRW    = 18'd1 << 11;
    localparam logic [17:0] RDST   = 18'd1 << 10;
    localparam logic [17:0] REGW   = 18'd1 << 9;
    localparam logic [17:0] SA     = 18'd1 << 8;
    localparam logic [17:0] SB_4   = 18'd1 << 6;
    localparam logic [17:0] SB_IMM = 18'd2 << 6;
    localparam logic [17:0] SB_SH  = 18'd3 << 6;
    localparam logic [17:0] PCS_AO = 18'd1 << 4;
    localparam logic [17:0] PCS_RS = 18'd2 << 4;
    localparam logic [17:0] AOP_SUB = 18'd1;
    localparam logic [17:0] AOP_FN  = 18'd2;

    localparam logic [17:0] C_F  = PCW | MRD | IRW | SB_4;
    localparam logic [17:0] C_FW = MRD;
    localparam logic [17:0] C_D  = SB_SH;
    localparam logic [17:0] C_EI = SA | SB_IMM;
    localparam logic [17:0] C_ER = SA | AOP_FN;
    localparam logic [17:0] C_EJ = PCW | PCS_RS;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    localparam logic [5:0] T_R     = 6'b000000;
    localparam logic [5:0] T_ADDIU = 6'b001001;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BAD   = 6'b111111;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_JR    = 6'b001000;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        wr;
        logic        az;
        logic        jz;
        logic [2:0]  st;
        logic        act;
        logic        ill;
        logic [17:0] ctl;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic wr, input logic jz,
                       input logic [2:0] st, input logic act, input logic ill,
                       input logic [17:0] ctl);
        vec_t v;
        v.op = o; v.funct = f; v.wr = wr; v.az = 1'b0; v.jz = jz;
        v.st = st; v.act = act; v.ill = ill; v.ctl = ctl;
        tbl.push_back(v);
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        op = v.op; funct = v.funct; waitrequest = v.wr; alu_zero = v.az; jr_tgt_zero = v.jz;
        #1;
        total++;
        if (state !== v.st) begin
            bad++;
            $display("FAIL v%0d state: got %0d want %0d", idx, state, v.st);
        end
        total++;
        if ({active, illegal} !== {v.act, v.ill}) begin
            bad++;
            $display("FAIL v%0d active/illegal: got %b%b want %b%b", idx, active, illegal,
                     v.act, v.ill);
        end
        total++;
        if (ctl_act !== v.ctl) begin
            bad++;
            $display("FAIL v%0d ctl: got %05h want %05h", idx, ctl_act, v.ctl);
        end
    endtask

    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic wr, input logic az,
                       input logic [2:0] st, input logic act, input logic ill,
                       input logic [17:0] ctl, input int idx);
        vec_t v;
        v.op = o; v.funct = f; v.wr = wr; v.az = az; v.jz = 1'b0;
        v.st = st; v.act = act; v.ill = ill; v.ctl = ctl;
        step(v, idx);
    endtask

    // Pulse reset, checking all outputs are zero while it is held.
    task automatic do_reset(input int idx);
        @(posedge clk);
        #2 rst_n = 1'b0;
        run(T_ADDIU, '0, 1'b0, 1'b0, S_F, 1'b0, 1'b0, '0, idx);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ADDIU
        add(T_ADDIU, '0, 0, 0, S_F, 1, 0, C_F);
        add(T_ADDIU, '0, 0, 0, S_D, 1, 0, C_D);
        add(T_ADDIU, '0, 0, 0, S_E, 1, 0, C_EI);
        add(T_ADDIU, '0, 0, 0, S_W, 1, 0, REGW);
        // LW, three stall cycles in MEM
        add(T_LW, '0, 0, 0, S_F, 1, 0, C_F);
        add(T_LW, '0, 0, 0, S_D, 1, 0, C_D);
        add(T_LW, '0, 0, 0, S_E, 1, 0, C_EI);
        for (int i = 0; i < 3; i++) add(T_LW, '0, 1, 0, S_M, 1, 0, IORD | MRD);
        add(T_LW, '0, 0, 0, S_M, 1, 0, IORD | MRD);
        add(T_LW, '0, 0, 0, S_W, 1, 0, REGW | MTR);
        // SW, two stall cycles in FETCH
        add(T_SW, '0, 1, 0, S_F, 1, 0, C_FW);
        add(T_SW, '0, 1, 0, S_F, 1, 0, C_FW);
        add(T_SW, '0, 0, 0, S_F, 1, 0, C_F);
        add(T_SW, '0, 0, 0, S_D, 1, 0, C_D);
        add(T_SW, '0, 0, 0, S_E, 1, 0, C_EI);
        add(T_SW, '0, 0, 0, S_M, 1, 0, IORD | MWR);
        // ADDU
        add(T_R, F_ADDU, 0, 0, S_F, 1, 0, C_F);
        add(T_R, F_ADDU, 0, 0, S_D, 1, 0, C_D);
        add(T_R, F_ADDU, 0, 0, S_E, 1, 0, C_ER);
        add(T_R, F_ADDU, 0, 0, S_W, 1, 0, REGW | RDST);
        // JR to nonzero target returns to FETCH
        add(T_R, F_JR, 0, 0, S_F, 1, 0, C_F);
        add(T_R, F_JR, 0, 0, S_D, 1, 0, C_D);
        add(T_R, F_JR, 0, 0, S_E, 1, 0, C_EJ);
        // JR to zero halts without setting illegal
        add(T_R, F_JR, 0, 1, S_F, 1, 0, C_F);
        add(T_R, F_JR, 0, 1, S_D, 1, 0, C_D);
        add(T_R, F_JR, 0, 1, S_E, 1, 0, C_EJ);
        add(T_R, F_JR, 0, 1, S_H, 0, 0, '0);
        add(T_R, F_JR, 0, 1, S_H, 0, 0, '0);

        run(T_ADDIU, '0, 1'b0, 1'b0, S_F, 1'b0, 1'b0, '0, 100);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Illegal opcode: halt sticky with illegal set
        do_reset(200);
        run(T_BAD, '0, 1'b0, 1'b0, S_F, 1'b1, 1'b0, C_F, 201);
        run(T_BAD, '0, 1'b0, 1'b0, S_D, 1'b1, 1'b0, C_D, 202);
        for (int i = 0; i < 12; i++) run(T_BAD, '0, 1'b0, 1'b0, S_H, 1'b0, 1'b1, '0, 210 + i);

        // Reset clears illegal; reset during a stalled SW kills mem_write at once
        do_reset(300);
        run(T_SW, '0, 1'b0, 1'b0, S_F, 1'b1, 1'b0, C_F, 301);
        run(T_SW, '0, 1'b0, 1'b0, S_D, 1'b1, 1'b0, C_D, 302);
        run(T_SW, '0, 1'b0, 1'b0, S_E, 1'b1, 1'b0, C_EI, 303);
        run(T_SW, '0, 1'b1, 1'b0, S_M, 1'b1, 1'b0, IORD | MWR, 304);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_write, mem_read, i_or_d, reg_write, active} !== 5'b0) begin
            bad++;
            $display("FAIL mid_mem_reset: got %b want 00000",
                     {mem_write, mem_read, i_or_d, reg_write, active});
        end
        @(posedge clk);
        #2 rst_n = 1'b1;

        // BEQ with alu_zero=1
        run(T_BEQ, '0, 1'b0, 1'b1, S_F, 1'b1, 1'b0, C_F, 400);
        run(T_BEQ, '0, 1'b0, 1'b1, S_D, 1'b1, 1'b0, C_D, 401);
`ifdef MIPS_CTRL_BRANCH_EN
        run(T_BEQ, '0, 1'b0, 1'b1, S_E, 1'b1, 1'b0, SA | AOP_SUB | PCS_AO | PCWC, 402);
        run(T_BEQ, '0, 1'b0, 1'b1, S_F, 1'b1, 1'b0, C_F, 403);
`else
        run(T_BEQ, '0, 1'b0, 1'b1, S_H, 1'b0, 1'b1, '0, 402);
        run(T_BEQ, '0, 1'b0, 1'b1, S_H, 1'b0, 1'b1, '0, 403);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
